frac_ce_synth: RTL and testbench

//  Multi-channel fractional clock-enable synthesiser running on one system clock.

---
 rtl/frac_ce_pkg.sv | 22 ++
 rtl/frac_ce_chan.sv | 120 ++++++++++++
 rtl/frac_ce_synth.sv | 131 +++++++++++++
 tb/tb_frac_ce_synth.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frac_ce_pkg.sv
// -----------------------------------------------------------------------------
// frac_ce_pkg
// Shared types and constants for the fractional clock-enable synthesiser.
//   ACC_W_DEFAULT : default (and largest supported) accumulator width
//   CH_W_MAX      : channel-select width that covers up to 8 channels
//   cfg_t         : one configuration request {ch, num, den, phase}
// -----------------------------------------------------------------------------
package frac_ce_pkg;

    localparam int ACC_W_DEFAULT = 32;
    localparam int CH_W_MAX      = 3;

    // Fields are sized for the largest supported configuration so the shadow
    // register layout does not depend on the top-level parameters.
    typedef struct packed {
        logic [CH_W_MAX-1:0]      ch;
        logic [ACC_W_DEFAULT-1:0] num;
        logic [ACC_W_DEFAULT-1:0] den;
        logic [ACC_W_DEFAULT-1:0] phase;
    } cfg_t;

endpackage

// File: rtl/frac_ce_chan.sv
// -----------------------------------------------------------------------------
// frac_ce_chan
// One fractional clock-enable channel: phase accumulator, wrap and half-period
// compares, registered ce/ce_n pulses and a saturating lock counter.
// Ports:
//   clk_sys, reset_n      : system clock, async active-low reset
//   enable_i              : run enable for this channel
//   apply_i               : load apply_num_i/apply_den_i/apply_phase_i this cycle
//   apply_*_i             : new increment, modulus and accumulator preload
//   run_o                 : channel is configured and enabled
//   wrap_o                : this cycle's update wraps (ce fires next cycle)
//   ce_o, ce_n_o          : registered wrap and half-period pulses
//   locked_o              : enough ce pulses seen since the last (re)configuration
// -----------------------------------------------------------------------------
module frac_ce_chan
    import frac_ce_pkg::*;
#(
    parameter int ACC_W       = ACC_W_DEFAULT,
    parameter int LOCK_PULSES = 16
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             enable_i,
    input  logic             apply_i,
    input  logic [ACC_W-1:0] apply_num_i,
    input  logic [ACC_W-1:0] apply_den_i,
    input  logic [ACC_W-1:0] apply_phase_i,
    output logic             run_o,
    output logic             wrap_o,
    output logic             ce_o,
    output logic             ce_n_o,
    output logic             locked_o
);

    localparam int CNT_W = $clog2(LOCK_PULSES + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_PULSES);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] num_q, num_d;
    logic [ACC_W-1:0] den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;
    logic             ce_n_q, ce_n_d;
    logic             locked_q, locked_d;

    logic             run;
    logic             wrap;
    logic             halfHit;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   diff;
    logic [ACC_W-1:0] half;

    // Accumulator step and compares. The sum keeps its carry bit so a wrap is
    // detected even when acc+num overflows ACC_W. The half-period point is
    // judged on the unwrapped sum, which keeps ce and ce_n on separate cycles
    // whenever 2*num <= den.
    always_comb begin
        run     = enable_i && (den_q != '0);
        sum     = {1'b0, acc_q} + {1'b0, num_q};
        diff    = sum - {1'b0, den_q};
        half    = den_q >> 1;
        wrap    = run && (sum >= {1'b0, den_q});
        halfHit = run && (acc_q < half) && ({1'b0, half} <= sum);
    end

    // Next-state selection. A new configuration takes priority over the
    // normal step and restarts locking; the ce of a wrapping apply cycle still
    // fires because ce_d only looks at the old configuration's wrap.
    always_comb begin
        acc_d    = acc_q;
        num_d    = num_q;
        den_d    = den_q;
        cnt_d    = cnt_q;
        ce_d     = wrap;
        ce_n_d   = halfHit;
        locked_d = run && !apply_i && (cnt_q == LOCK_MAX);

        if (apply_i) begin
            num_d = apply_num_i;
            den_d = apply_den_i;
            acc_d = apply_phase_i;
            cnt_d = '0;
        end else if (!run) begin
            cnt_d = '0;
        end else begin
            acc_d = wrap ? diff[ACC_W-1:0] : sum[ACC_W-1:0];
            if (wrap && (cnt_q != LOCK_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            num_q    <= '0;
            den_q    <= '0;
            cnt_q    <= '0;
            ce_q     <= 1'b0;
            ce_n_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            num_q    <= num_d;
            den_q    <= den_d;
            cnt_q    <= cnt_d;
            ce_q     <= ce_d;
            ce_n_q   <= ce_n_d;
            locked_q <= locked_d;
        end
    end

    assign run_o    = run;
    assign wrap_o   = wrap;
    assign ce_o     = ce_q;
    assign ce_n_o   = ce_n_q;
    assign locked_o = locked_q;

endmodule

// File: rtl/frac_ce_synth.sv
// -----------------------------------------------------------------------------
// frac_ce_synth
// Multi-channel fractional clock-enable synthesiser. Each channel produces ce
// and a half-period-offset ce_n averaging f_clk*NUM/DEN. Configuration arrives
// over a valid/ready port, is validated on the transfer cycle, held in a single
// shadow register and applied to its channel at that channel's next wrap (or
// the following cycle if the channel is idle).
// Ports:
//   clk_sys, reset_n            : system clock, async active-low reset
//   cfg_valid / cfg_ready       : configuration handshake
//   cfg_ch/num/den/phase        : target channel, increment, modulus, preload
//   cfg_err                     : one-cycle pulse when a request is rejected
//   enable                      : per-channel run enable
//   ce, ce_n                    : per-channel wrap / half-period pulses
//   locked, locked_all          : per-channel lock and their AND
// Supports ACC_W up to frac_ce_pkg::ACC_W_DEFAULT and CHANNELS from 1 to 8.
// -----------------------------------------------------------------------------
module frac_ce_synth
    import frac_ce_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = ACC_W_DEFAULT,
    parameter int LOCK_PULSES = 16,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
    input  logic [ACC_W-1:0]    cfg_phase,
    output logic                cfg_err,
    input  logic [CHANNELS-1:0] enable,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] ce_n,
    output logic [CHANNELS-1:0] locked,
    output logic                locked_all
);

    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    cfg_t                shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic                cfg_err_q, cfg_err_d;
    logic                fire;
    logic                bad;
    logic                applyAny;
    logic [CHANNELS-1:0] applyVec;
    logic [CHANNELS-1:0] runVec;
    logic [CHANNELS-1:0] wrapVec;

    // Request validation. Doubling num keeps its carry so 2*num>den is exact.
    always_comb begin
        fire = cfg_valid && cfg_ready;
        bad  = (cfg_num == '0)
            || (cfg_den == '0)
            || ({cfg_num, 1'b0} > {1'b0, cfg_den})
            || (cfg_phase >= cfg_den)
            || ({1'b0, cfg_ch} >= CH_LIMIT);
    end

    // Handshake and shadow register. A transfer can only fire while nothing is
    // pending and an apply only happens while something is, so the two never
    // collide.
    always_comb begin
        pending_d = pending_q;
        shadow_d  = shadow_q;
        cfg_err_d = 1'b0;
        if (applyAny) begin
            pending_d = 1'b0;
        end
        if (fire) begin
            if (bad) begin
                cfg_err_d = 1'b1;
            end else begin
                pending_d      = 1'b1;
                shadow_d.ch    = CH_W_MAX'(cfg_ch);
                shadow_d.num   = ACC_W_DEFAULT'(cfg_num);
                shadow_d.den   = ACC_W_DEFAULT'(cfg_den);
                shadow_d.phase = ACC_W_DEFAULT'(cfg_phase);
            end
        end
    end

    // Handshake state registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Apply routing: the pending config lands on its channel's wrap cycle, or
    // straight away when that channel is not running.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign applyVec[g] = pending_q
                          && (shadow_q.ch == CH_W_MAX'(g))
                          && (wrapVec[g] || !runVec[g]);

        frac_ce_chan #(
            .ACC_W       (ACC_W),
            .LOCK_PULSES (LOCK_PULSES)
        ) u_chan (
            .clk_sys       (clk_sys),
            .reset_n       (reset_n),
            .enable_i      (enable[g]),
            .apply_i       (applyVec[g]),
            .apply_num_i   (shadow_q.num[ACC_W-1:0]),
            .apply_den_i   (shadow_q.den[ACC_W-1:0]),
            .apply_phase_i (shadow_q.phase[ACC_W-1:0]),
            .run_o         (runVec[g]),
            .wrap_o        (wrapVec[g]),
            .ce_o          (ce[g]),
            .ce_n_o        (ce_n[g]),
            .locked_o      (locked[g])
        );
    end

    assign applyAny   = |applyVec;
    assign cfg_ready  = !pending_q;
    assign cfg_err    = cfg_err_q;
    assign locked_all = &locked;

endmodule

// File: tb/tb_frac_ce_synth.sv
// -----------------------------------------------------------------------------
// tb_frac_ce_synth
// Directed self-checking bench for frac_ce_synth (2 channels, 32-bit, 16-pulse
// lock). Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_frac_ce_synth;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [0:0]  cfg_ch = '0;
    logic [31:0] cfg_num = '0;
    logic [31:0] cfg_den = '0;
    logic [31:0] cfg_phase = '0;
    logic        cfg_err;
    logic [1:0]  enable = '0;
    logic [1:0]  ce;
    logic [1:0]  ce_n;
    logic [1:0]  locked;
    logic        locked_all;

    int checks = 0;
    int errors = 0;

    frac_ce_synth #(
        .CHANNELS    (2),
        .ACC_W       (32),
        .LOCK_PULSES (16)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_num    (cfg_num),
        .cfg_den    (cfg_den),
        .cfg_phase  (cfg_phase),
        .cfg_err    (cfg_err),
        .enable     (enable),
        .ce         (ce),
        .ce_n       (ce_n),
        .locked     (locked),
        .locked_all (locked_all)
    );

    always #5 clk_sys = ~clk_sys;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one configuration for a single transfer edge.
    task automatic applyStimulus(input logic [0:0] ch, input logic [31:0] num,
                                 input logic [31:0] den, input logic [31:0] phase);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_num   = num;
        cfg_den   = den;
        cfg_phase = phase;
        tick(1);
        cfg_valid = 1'b0;
    endtask

    // Settle on a cycle where ce[0] is high (ch0 has just wrapped).
    task automatic waitCe0();
        int n = 0;
        while (ce[0] !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checkOutput("ce0_sync", ce[0], 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int ceCnt;
        int cenCnt;
        int u;

        // ---------------- reset ----------------
        #2 reset_n = 1'b0;
        tick(2);
        checkOutput("rst_ready", cfg_ready, 1'b1);
        checkOutput("rst_ce", ce, 2'b00);
        checkOutput("rst_ce_n", ce_n, 2'b00);
        checkOutput("rst_locked", locked, 2'b00);
        checkOutput("rst_err", cfg_err, 1'b0);
        checkOutput("rst_locked_all", locked_all, 1'b0);
        reset_n = 1'b1;
        tick(1);

        // ---------------- 1: ch0 1/4 ----------------
        applyStimulus(1'b0, 32'd1, 32'd4, 32'd0);
        checkOutput("t1_ready_pending", cfg_ready, 1'b0);
        tick(1);
        checkOutput("t1_ready_applied", cfg_ready, 1'b1);
        enable = 2'b01;
        for (int k = 1; k <= 65; k++) begin
            tick(1);
            if (k <= 64) begin
                checkOutput("t1_ce0", ce[0], (k % 4 == 0));
                checkOutput("t1_ce_n0", ce_n[0], (k % 4 == 2));
            end
            if (k == 64) checkOutput("t1_locked_before", locked[0], 1'b0);
            if (k == 65) checkOutput("t1_locked_after", locked[0], 1'b1);
        end

        // ---------------- 2: ch1 3/8 ----------------
        applyStimulus(1'b1, 32'd3, 32'd8, 32'd0);
        checkOutput("t2_ready_pending", cfg_ready, 1'b0);
        tick(1);
        checkOutput("t2_ready_applied", cfg_ready, 1'b1);
        enable = 2'b11;
        ceCnt = 0;
        cenCnt = 0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            u = (k - 1) % 8;
            checkOutput("t2_ce1", ce[1], (u == 2 || u == 5 || u == 7));
            checkOutput("t2_ce_n1", ce_n[1], (u == 1 || u == 3 || u == 6));
            checkOutput("t2_no_overlap", ce[1] & ce_n[1], 1'b0);
            ceCnt += int'(ce[1]);
            cenCnt += int'(ce_n[1]);
        end
        checkOutput("t2_ce_count", ceCnt, 6);
        checkOutput("t2_ce_n_count", cenCnt, 6);

        // ---------------- 3: rejected configs ----------------
        applyStimulus(1'b0, 32'd5, 32'd8, 32'd0);
        checkOutput("t3a_err", cfg_err, 1'b1);
        checkOutput("t3a_ready", cfg_ready, 1'b1);
        tick(1);
        checkOutput("t3a_err_clear", cfg_err, 1'b0);
        applyStimulus(1'b0, 32'd1, 32'd0, 32'd0);
        checkOutput("t3b_err", cfg_err, 1'b1);
        checkOutput("t3b_ready", cfg_ready, 1'b1);
        tick(1);
        checkOutput("t3b_err_clear", cfg_err, 1'b0);
        applyStimulus(1'b0, 32'd1, 32'd8, 32'd8);
        checkOutput("t3c_err", cfg_err, 1'b1);
        checkOutput("t3c_ready", cfg_ready, 1'b1);
        tick(1);
        checkOutput("t3c_err_clear", cfg_err, 1'b0);
        checkOutput("t3_locked0_kept", locked[0], 1'b1);
        waitCe0();
        n = 0;
        do begin
            tick(1);
            n++;
        end while (ce[0] !== 1'b1 && n < 20);
        checkOutput("t3_ce0_period", n, 4);

        // ---------------- 4: reconfigure ch0 to 1/2 ----------------
        waitCe0();
        applyStimulus(1'b0, 32'd1, 32'd2, 32'd0);
        checkOutput("t4_ready_e1", cfg_ready, 1'b0);
        tick(1);
        checkOutput("t4_ready_e2", cfg_ready, 1'b0);
        tick(1);
        checkOutput("t4_ready_e3", cfg_ready, 1'b0);
        tick(1);
        checkOutput("t4_ready_apply", cfg_ready, 1'b1);
        checkOutput("t4_ce_old_wrap", ce[0], 1'b1);
        checkOutput("t4_locked_drop", locked[0], 1'b0);
        for (int j = 1; j <= 33; j++) begin
            tick(1);
            if (j <= 32) begin
                checkOutput("t4_ce0", ce[0], (j % 2 == 0));
                checkOutput("t4_ce_n0", ce_n[0], (j % 2 == 1));
            end
            if (j == 32) checkOutput("t4_relock_before", locked[0], 1'b0);
            if (j == 33) checkOutput("t4_relock_after", locked[0], 1'b1);
        end

        // ---------------- 5: phase offset ----------------
        enable = 2'b00;
        tick(1);
        applyStimulus(1'b0, 32'd1, 32'd4, 32'd0);
        tick(1);
        checkOutput("t5_ready_ch0", cfg_ready, 1'b1);
        applyStimulus(1'b1, 32'd1, 32'd4, 32'd2);
        tick(1);
        checkOutput("t5_ready_ch1", cfg_ready, 1'b1);
        enable = 2'b11;
        for (int k = 1; k <= 65; k++) begin
            tick(1);
            if (k <= 8) begin
                checkOutput("t5_ce0", ce[0], (k % 4 == 0));
                checkOutput("t5_ce1", ce[1], (k % 4 == 2));
                checkOutput("t5_ce_n0", ce_n[0], (k % 4 == 2));
                checkOutput("t5_ce_n1", ce_n[1], (k % 4 == 0));
            end
            if (k == 64) begin
                checkOutput("t5_locked_64", locked, 2'b10);
                checkOutput("t5_locked_all_64", locked_all, 1'b0);
            end
            if (k == 65) begin
                checkOutput("t5_locked_65", locked, 2'b11);
                checkOutput("t5_locked_all_65", locked_all, 1'b1);
            end
        end
        enable = 2'b01;
        tick(1);
        checkOutput("t5_drop_locked", locked, 2'b01);
        checkOutput("t5_drop_locked_all", locked_all, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("t5_ce1_stopped", ce[1], 1'b0);
            checkOutput("t5_ce_n1_stopped", ce_n[1], 1'b0);
            tick(1);
        end

        // ---------------- 6: reset with pending config ----------------
        waitCe0();
        applyStimulus(1'b0, 32'd1, 32'd2, 32'd0);
        checkOutput("t6_pending", cfg_ready, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_ready", cfg_ready, 1'b1);
        checkOutput("t6_rst_ce", ce, 2'b00);
        checkOutput("t6_rst_ce_n", ce_n, 2'b00);
        checkOutput("t6_rst_locked", locked, 2'b00);
        checkOutput("t6_rst_locked_all", locked_all, 1'b0);
        checkOutput("t6_rst_err", cfg_err, 1'b0);
        tick(2);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            checkOutput("t6_post_ce", ce, 2'b00);
            checkOutput("t6_post_ce_n", ce_n, 2'b00);
            checkOutput("t6_post_ready", cfg_ready, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
